// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-bounded sharing of the FIFO push port among NUM_REQ requesters.
// Define FIFO_ARB_AF_HOLD_EN to block every push while the FIFO reports almost-full.
module fifo_push_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_push,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          push_req_n,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          push_full,
  input  logic                          push_af,
  input  logic                          push_error,
  input  logic                          err_clr,
  output logic                          arb_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, BURST, STALL, ERROR} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, last_q, last_d, pick, idx, src;
  logic [BW-1:0] burst_q, burst_d;
  logic push_req_n_q, push_req_n_d, room, acc, other;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
`ifdef FIFO_ARB_AF_HOLD_EN
  assign room = !push_full && !push_af;
`else
  // At almost-full a push is only allowed if the previous cycle did not push.
  assign room = !push_full && (push_req_n_q || !push_af);
`endif
  assign other      = |(req_valid & ~(NUM_REQ'(1) << gnt_q));
  assign gnt_id     = gnt_q;
  assign push_req_n = push_req_n_q;
  assign data_in    = data_q;
  assign arb_err    = state_q == ERROR;
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      pick = req_valid[idx] ? idx : pick;
    end
  end
  always_ff @(posedge clk_push) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_q       <= GW'(NUM_REQ - 1);
      burst_q      <= '0;
      push_req_n_q <= 1'b1;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      burst_q      <= burst_d;
      push_req_n_q <= push_req_n_d;
      data_q       <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (push_error) state_d = ERROR;
    else case (state_q)
      IDLE: if (|req_valid) begin
        gnt_d   = pick;
        last_d  = pick;
        burst_d = acc ? BW'(1) : '0;
        state_d = acc ? BURST : STALL;
      end
      BURST: if (!req_valid[gnt_q]) state_d = IDLE;
      else if (acc) begin
        burst_d = (burst_q + BW'(1) == MAXB && !other) ? '0 : burst_q + BW'(1);
        state_d = (burst_q + BW'(1) == MAXB && other) ? IDLE : BURST;
      end else if (burst_q == MAXB) begin
        burst_d = other ? burst_q : '0;
        state_d = other ? IDLE : BURST;
      end else if (push_full) state_d = STALL;
      STALL: state_d = room ? BURST : STALL;
      default: state_d = err_clr ? IDLE : ERROR;
    endcase
  end
  always_comb begin
    req_ready = '0;
    if (rst_n && !push_error && room) begin
      if (state_q == IDLE && |req_valid) req_ready[pick] = 1'b1;
      if (state_q == BURST && burst_q < MAXB) req_ready[gnt_q] = 1'b1;
    end
    acc          = |(req_ready & req_valid);
    src          = state_q == IDLE ? pick : gnt_q;
    push_req_n_d = !acc;
    data_d       = acc ? lane[src] : data_q;
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios for fifo_push_arbiter with hand-computed expectations.
module tb_fifo_push_arbiter;
  logic         clk_push = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [1:0]   gnt_id;
  logic         push_req_n;
  logic [31:0]  data_in;
  logic         push_full = 1'b0, push_af = 1'b0, push_error = 1'b0, err_clr = 1'b0;
  logic         arb_err;
  int n_cmp = 0, n_fail = 0;

  fifo_push_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk_push(clk_push), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .gnt_id(gnt_id), .push_req_n(push_req_n), .data_in(data_in),
    .push_full(push_full), .push_af(push_af), .push_error(push_error), .err_clr(err_clr),
    .arb_err(arb_err)
  );

  always #5 clk_push = ~clk_push;

  function automatic logic [31:0] lane(input int i);
    return 32'hA5A5_0001 + 32'(i) * 32'h100;
  endfunction

  task automatic tick;
    @(posedge clk_push);
    @(negedge clk_push);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; push_full = 0; push_af = 0; push_error = 0; err_clr = 0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'b1111;
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id, arb_err} !== {1'b1, 32'h0, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_outputs got %b/%h/%0d/%b want 1/00000000/0/0", push_req_n, data_in, gnt_id, arb_err); end
    n_cmp++; if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    req_valid = '0; rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id} !== {1'b0, 32'hA5A5_0001, 2'd0}) begin
      n_fail++; $display("FAIL single_push got %b/%h/%0d want 0/a5a50001/0", push_req_n, data_in, gnt_id); end
    req_valid = '0;
    tick;
    n_cmp++; if ({push_req_n, data_in} !== {1'b1, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL single_hold got %b/%h want 1/a5a50001", push_req_n, data_in); end
    tick;
  endtask

  task automatic test_round_robin;
    do_reset;
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      int e;
      e = (k / 4) % 4;
      tick;
      n_cmp++; if ({push_req_n, data_in, gnt_id} !== {1'b0, lane(e), 2'(e)}) begin
        n_fail++; $display("FAIL rr_cycle%0d got %b/%h/%0d want 0/%h/%0d", k, push_req_n, data_in, gnt_id, lane(e), e); end
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_full;
    logic [31:0] pushes [8];
    int np;
    np = 0;
    do_reset;
    req_valid = 4'b0110;
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id} !== {1'b0, lane(1), 2'd1}) begin
      n_fail++; $display("FAIL full_first got %b/%h/%0d want 0/%h/1", push_req_n, data_in, gnt_id, lane(1)); end
    tick;
    push_full = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL full_ready got %b want 0000", req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if ({push_req_n, req_ready} !== {1'b1, 4'b0000}) begin
        n_fail++; $display("FAIL full_hold%0d got %b/%b want 1/0000", k, push_req_n, req_ready); end
    end
    push_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (!push_req_n && np < 8) begin pushes[np] = data_in; np++; end
    end
    n_cmp++; if (np !== 5) begin
      n_fail++; $display("FAIL full_resume_count got %0d want 5", np); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] w;
      w = (k < 2) ? lane(1) : lane(2);
      n_cmp++; if (k >= np || pushes[k] !== w) begin
        n_fail++; $display("FAIL full_resume%0d got %h want %h", k, (k < np) ? pushes[k] : 32'hx, w); end
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_af;
    do_reset;
    req_valid = 4'b0001; push_af = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic e;
`ifdef FIFO_ARB_AF_HOLD_EN
      e = 1'b1;
`else
      e = k[0];
`endif
      tick;
      n_cmp++; if (push_req_n !== e) begin
        n_fail++; $display("FAIL af_cycle%0d got %b want %b", k, push_req_n, e); end
    end
    req_valid = '0; push_af = 1'b0;
    tick;
  endtask

  task automatic test_error;
    do_reset;
    req_valid = 4'b0001;
    tick;
    tick;
    push_error = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL err_ready got %b want 0000", req_ready); end
    tick;
    n_cmp++; if ({arb_err, push_req_n} !== 2'b11) begin
      n_fail++; $display("FAIL err_enter got %b/%b want 1/1", arb_err, push_req_n); end
    push_error = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_cmp++; if ({arb_err, push_req_n} !== 2'b11) begin
        n_fail++; $display("FAIL err_hold%0d got %b/%b want 1/1", k, arb_err, push_req_n); end
    end
    push_error = 1'b1; err_clr = 1'b1;
    tick;
    n_cmp++; if (arb_err !== 1'b1) begin
      n_fail++; $display("FAIL err_clr_blocked got %b want 1", arb_err); end
    push_error = 1'b0;
    tick;
    n_cmp++; if ({arb_err, push_req_n} !== 2'b01) begin
      n_fail++; $display("FAIL err_clear got %b/%b want 0/1", arb_err, push_req_n); end
    err_clr = 1'b0;
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id} !== {1'b0, lane(0), 2'd0}) begin
      n_fail++; $display("FAIL err_resume got %b/%h/%0d want 0/%h/0", push_req_n, data_in, gnt_id, lane(0)); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_midreset;
    do_reset;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) tick;
    n_cmp++; if (gnt_id !== 2'd1) begin
      n_fail++; $display("FAIL mid_pre_gnt got %0d want 1", gnt_id); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id, arb_err} !== {1'b1, 32'h0, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_rst_outputs got %b/%h/%0d/%b want 1/00000000/0/0", push_req_n, data_in, gnt_id, arb_err); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_ready got %b want 0001", req_ready); end
    tick;
    n_cmp++; if ({push_req_n, data_in, gnt_id} !== {1'b0, lane(0), 2'd0}) begin
      n_fail++; $display("FAIL mid_first_push got %b/%h/%0d want 0/%h/0", push_req_n, data_in, gnt_id, lane(0)); end
    req_valid = '0;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = lane(i);
    @(negedge clk_push);
    test_reset;
    test_single;
    test_round_robin;
    test_full;
    test_af;
    test_error;
    test_midreset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
